// File: rtl/sram_master_pkg.sv
// sram_master_pkg: shared types and constants for the SRAM bus initiator.
//   state_e      - FSM state encoding
//   sram_ctl_t   - SRAM-side strobe/drive bundle
//   state_ctl()  - maps a state to its strobe/drive levels
//   WAIT_CNT_W / TURN_CNT_W and the legal WaitStates/TurnCycles ranges
package sram_master_pkg;

    localparam int unsigned WAIT_CNT_W      = 4;
    localparam int unsigned TURN_CNT_W      = 3;
    localparam int unsigned WAIT_STATES_MAX = 15;
    localparam int unsigned TURN_CYCLES_MIN = 1;
    localparam int unsigned TURN_CYCLES_MAX = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WSETUP  = 3'd2,
        ST_WSTROBE = 3'd3,
        ST_WHOLD   = 3'd4,
        ST_TURN    = 3'd5
    } state_e;

    typedef struct packed {
        logic ce_b;
        logic re_b;
        logic we_b;
        logic drive;
    } sram_ctl_t;

    // Strobe levels held for the whole time the FSM sits in a state.
    function automatic sram_ctl_t state_ctl(input state_e st);
        sram_ctl_t c;
        c = '{ce_b: 1'b1, re_b: 1'b1, we_b: 1'b1, drive: 1'b0};
        case (st)
            ST_READ: begin
                c.ce_b = 1'b0;
                c.re_b = 1'b0;
            end
            ST_WSETUP, ST_WHOLD: begin
                c.ce_b  = 1'b0;
                c.drive = 1'b1;
            end
            ST_WSTROBE: begin
                c.ce_b  = 1'b0;
                c.we_b  = 1'b0;
                c.drive = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sram_master_timer.sv
// sram_master_timer: loadable down-counter with zero flag.
//   i_clk, i_rst   - clock, synchronous active-high reset (count -> 0)
//   i_load/i_value - load count (has priority over decrement)
//   i_en           - decrement while non-zero
//   o_zero_c       - count == 0 (combinational from the count register)
module sram_master_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [Width-1:0] i_value,
    input  logic             i_en,
    output logic             o_zero_c
);

    logic [Width-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_value;
        end else if (i_en && (count != '0)) begin
            count <= count - Width'(1);
        end
    end

    assign o_zero_c = (count == '0);

endmodule

// File: rtl/sram_master.sv
// sram_master: clocked initiator for an asynchronous byte-wide SRAM.
// Turns a req/ready handshake into registered, glitch-free ce/re/we strobe
// sequences with WaitStates extra strobe cycles and TurnCycles of bus idle.
// Optional build macro SRAM_MASTER_AUTOINC_EN adds an auto-incrementing
// address pointer (ports i_ptr_load, i_use_ptr).
// Ports:
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_req, i_we, i_addr,
//   i_wdata                   - request, direction, address, write data
//   o_ready                   - idle; request accepted on i_req & o_ready
//   o_done                    - one-cycle completion pulse
//   o_rdata                   - last read byte
//   o_ce_b, o_re_b, o_we_b    - SRAM strobes, active-low
//   o_addr                    - SRAM address
//   io_data                   - SRAM data, driven only in write states
module sram_master
    import sram_master_pkg::*;
#(
    parameter int unsigned AddrWidth  = 16,
    parameter int unsigned WaitStates = 2,
    parameter int unsigned TurnCycles = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
`ifdef SRAM_MASTER_AUTOINC_EN
    input  logic                 i_ptr_load,
    input  logic                 i_use_ptr,
`endif
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [7:0]           i_wdata,
    output logic                 o_ready,
    output logic                 o_done,
    output logic [7:0]           o_rdata,
    output logic                 o_ce_b,
    output logic                 o_re_b,
    output logic                 o_we_b,
    output logic [AddrWidth-1:0] o_addr,
    inout  wire  [7:0]           io_data
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WaitStates);
    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TurnCycles - 1);

    // Elaboration-time parameter range checks.
    if (WaitStates > WAIT_STATES_MAX) begin : g_bad_wait
        $error("sram_master: WaitStates must be 0..15");
    end
    if ((TurnCycles < TURN_CYCLES_MIN) || (TurnCycles > TURN_CYCLES_MAX)) begin : g_bad_turn
        $error("sram_master: TurnCycles must be 1..7");
    end

    state_e                 state;
    state_e                 state_next;
    sram_ctl_t              ctl_next_c;
    logic                   accept_c;
    logic                   wait_load_c;
    logic                   wait_en_c;
    logic                   wait_zero_c;
    logic                   turn_load_c;
    logic                   turn_en_c;
    logic                   turn_zero_c;
    logic [AddrWidth-1:0]   addr_sel_c;
    logic [7:0]             wdata_q;
    logic                   drive_q;

`ifdef SRAM_MASTER_AUTOINC_EN
    logic [AddrWidth-1:0]   ptr;

    // A pointer load in IDLE blocks the access start for that cycle.
    assign accept_c   = i_req && (state == ST_IDLE) && !i_ptr_load;
    assign addr_sel_c = i_use_ptr ? ptr : i_addr;

    // Auto-increment pointer, post-incremented on a pointer-based accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr <= '0;
        end else if ((state == ST_IDLE) && i_ptr_load) begin
            ptr <= i_addr;
        end else if (accept_c && i_use_ptr) begin
            ptr <= ptr + AddrWidth'(1);
        end
    end
`else
    assign accept_c   = i_req && (state == ST_IDLE);
    assign addr_sel_c = i_addr;
`endif

    // Wait counter serves READ and WSTROBE; TURN counter serves TURN.
    sram_master_timer #(.Width(WAIT_CNT_W)) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (wait_load_c),
        .i_value  (WAIT_LOAD),
        .i_en     (wait_en_c),
        .o_zero_c (wait_zero_c)
    );

    sram_master_timer #(.Width(TURN_CNT_W)) u_turn_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (turn_load_c),
        .i_value  (TURN_LOAD),
        .i_en     (turn_en_c),
        .o_zero_c (turn_zero_c)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_next  = state;
        wait_load_c = 1'b0;
        turn_load_c = 1'b0;
        wait_en_c   = (state == ST_READ) || (state == ST_WSTROBE);
        turn_en_c   = (state == ST_TURN);
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_next  = i_we ? ST_WSETUP : ST_READ;
                    wait_load_c = !i_we;
                end
            end
            ST_READ: begin
                if (wait_zero_c) begin
                    state_next  = ST_TURN;
                    turn_load_c = 1'b1;
                end
            end
            ST_WSETUP: begin
                state_next  = ST_WSTROBE;
                wait_load_c = 1'b1;
            end
            ST_WSTROBE: begin
                if (wait_zero_c) begin
                    state_next = ST_WHOLD;
                end
            end
            ST_WHOLD: begin
                state_next  = ST_TURN;
                turn_load_c = 1'b1;
            end
            ST_TURN: begin
                if (turn_zero_c) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        ctl_next_c = state_ctl(state_next);
    end

    // Strobes are registered from the next state so they switch cleanly with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ready <= 1'b1;
            o_done  <= 1'b0;
            o_rdata <= '0;
            o_ce_b  <= 1'b1;
            o_re_b  <= 1'b1;
            o_we_b  <= 1'b1;
            o_addr  <= '0;
            wdata_q <= '0;
            drive_q <= 1'b0;
        end else begin
            o_ready <= (state_next == ST_IDLE);
            o_done  <= (state_next == ST_TURN) && (state != ST_TURN);
            o_ce_b  <= ctl_next_c.ce_b;
            o_re_b  <= ctl_next_c.re_b;
            o_we_b  <= ctl_next_c.we_b;
            drive_q <= ctl_next_c.drive;
            if (accept_c) begin
                o_addr  <= addr_sel_c;
                wdata_q <= i_wdata;
            end
            // Capture on the edge that ends the last READ cycle.
            if ((state == ST_READ) && wait_zero_c) begin
                o_rdata <= io_data;
            end
        end
    end

    assign io_data = drive_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_sram_master.sv
// tb_sram_master: directed + random bench for sram_master with an SRAM model,
// a scoreboard queue and per-cycle bus invariant checks.
module tb_sram_master;

    localparam int unsigned AW = 16;
    localparam int unsigned WS = 2;
    localparam int unsigned TC = 1;
    localparam int RD_LAT = int'(WS) + 1;
    localparam int WR_LAT = int'(WS) + 3;
    localparam int STROBE = int'(WS) + 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_req;
    logic          i_we;
    logic [AW-1:0] i_addr;
    logic [7:0]    i_wdata;
`ifdef SRAM_MASTER_AUTOINC_EN
    logic          i_ptr_load;
    logic          i_use_ptr;
`endif
    logic          o_ready;
    logic          o_done;
    logic [7:0]    o_rdata;
    logic          o_ce_b;
    logic          o_re_b;
    logic          o_we_b;
    logic [AW-1:0] o_addr;
    tri1  [7:0]    io_data;

    logic [7:0]    mem     [0:(1<<AW)-1];
    logic [7:0]    ref_mem [0:(1<<AW)-1];
    exp_t          sb [$];

    int            n_tests   = 0;
    int            n_fail    = 0;
    int            n_done    = 0;
    int            n_accept  = 0;
    int            n_aborted = 0;
    int            cyc       = 0;
    int            accept_cyc = 0;
    logic          chk_en    = 1'b0;
    logic [AW-1:0] model_ptr = '0;

    always #5 clk = ~clk;

    // SRAM model read path: drives the bus while ce_b and re_b are low.
    assign io_data = (!o_ce_b && !o_re_b) ? mem[o_addr] : 8'hzz;

    sram_master #(.AddrWidth(AW), .WaitStates(WS), .TurnCycles(TC)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
`ifdef SRAM_MASTER_AUTOINC_EN
        .i_ptr_load (i_ptr_load),
        .i_use_ptr  (i_use_ptr),
`endif
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_ready    (o_ready),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_ce_b     (o_ce_b),
        .o_re_b     (o_re_b),
        .o_we_b     (o_we_b),
        .o_addr     (o_addr),
        .io_data    (io_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [7:0] data,
                         input logic use_ptr, input logic hold);
        logic [AW-1:0] eff;
        i_req   = 1'b1;
        i_we    = we;
        i_addr  = addr;
        i_wdata = data;
`ifdef SRAM_MASTER_AUTOINC_EN
        i_use_ptr = use_ptr;
`endif
        for (int k = 0; (k < 100) && !o_ready; k++) @(negedge clk);
        if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
        eff = use_ptr ? model_ptr : addr;
        if (use_ptr) model_ptr = model_ptr + AW'(1);
        sb.push_back('{we, eff, (we ? data : ref_mem[eff])});
        if (we) ref_mem[eff] = data;
        @(negedge clk);
        accept_cyc = cyc;
        n_accept++;
        if (!hold) i_req = 1'b0;
    endtask

    // Counts strobe-low cycles from the current negedge up to o_done.
    task automatic wait_done(output int re_low, output int we_low, output int ce_low);
        re_low = 0;
        we_low = 0;
        ce_low = 0;
        for (int k = 0; k < 64; k++) begin
            if (o_done) return;
            if (!o_re_b) re_low++;
            if (!o_we_b) we_low++;
            if (!o_ce_b) ce_low++;
            @(negedge clk);
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; (k < 400) && ((sb.size() != 0) || !o_ready); k++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        exp_t          e;
        logic          prev_ce_b;
        logic [AW-1:0] prev_addr;
        int            re_low, we_low, ce_low, t0, done0;

        i_rst   = 1'b1;
        i_req   = 1'b0;
        i_we    = 1'b0;
        i_addr  = '0;
        i_wdata = '0;
`ifdef SRAM_MASTER_AUTOINC_EN
        i_ptr_load = 1'b0;
        i_use_ptr  = 1'b0;
`endif
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[16'h1234]     = 8'hA5;
        ref_mem[16'h1234] = 8'hA5;
        prev_ce_b = 1'b1;
        prev_addr = '0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            // SRAM model write: latch data on the rising edge of we_b.
            forever begin
                @(posedge o_we_b);
                if (!o_ce_b) mem[o_addr] = io_data;
            end
            // Scoreboard: pop and compare on every completion pulse.
            forever begin
                @(negedge clk);
                if (chk_en && o_done) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        if (e.we) chk("write_mem", 32'(mem[e.addr]), 32'(e.data));
                        else      chk("read_data", 32'(o_rdata), 32'(e.data));
                    end
                end
            end
            // Bus invariants, sampled every cycle.
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("re_we_excl", 32'(o_re_b | o_we_b), 32'd1);
                    if (o_ce_b) chk("bus_released", 32'(io_data), 32'hFF);
                    if (!o_re_b) chk("read_bus", 32'(io_data), 32'(mem[o_addr]));
                    if (!o_ce_b && !prev_ce_b) chk("addr_stable", 32'(o_addr), 32'(prev_addr));
                end
                prev_ce_b = o_ce_b;
                prev_addr = o_addr;
            end
            begin
                #1_000_000;
                $display("FAIL watchdog: observed no finish, expected finish before 1ms");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ce_b",  32'(o_ce_b),  32'd1);
        chk("rst_re_b",  32'(o_re_b),  32'd1);
        chk("rst_we_b",  32'(o_we_b),  32'd1);
        chk("rst_addr",  32'(o_addr),  32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_done",  32'(o_done),  32'd0);
        chk("rst_bus",   32'(io_data), 32'hFF);
        i_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(o_ready), 32'd1);
        chk_en = 1'b1;

        // Read 0x1234 holding 0xA5.
        issue(1'b0, 16'h1234, 8'h00, 1'b0, 1'b0);
        t0 = accept_cyc;
        wait_done(re_low, we_low, ce_low);
        chk("rd_re_low",   32'(re_low), 32'(STROBE));
        chk("rd_we_low",   32'(we_low), 32'd0);
        chk("rd_latency",  32'(cyc - t0), 32'(RD_LAT));
        chk("rd_1234",     32'(o_rdata), 32'hA5);

        // Write 0x5A to 0x00FF, then read it back.
        issue(1'b1, 16'h00FF, 8'h5A, 1'b0, 1'b0);
        t0 = accept_cyc;
        wait_done(re_low, we_low, ce_low);
        chk("wr_we_low",   32'(we_low), 32'(STROBE));
        chk("wr_ce_low",   32'(ce_low), 32'(STROBE + 2));
        chk("wr_re_low",   32'(re_low), 32'd0);
        chk("wr_latency",  32'(cyc - t0), 32'(WR_LAT));
        chk("wr_mem_00ff", 32'(mem[16'h00FF]), 32'h5A);
        issue(1'b0, 16'h00FF, 8'h00, 1'b0, 1'b0);
        wait_done(re_low, we_low, ce_low);
        chk("rdback_00ff", 32'(o_rdata), 32'h5A);
        drain();

        // Back-to-back read then write with i_req held.
        issue(1'b0, 16'h1234, 8'h00, 1'b0, 1'b1);
        t0 = accept_cyc;
        issue(1'b1, 16'h0100, 8'hC3, 1'b0, 1'b0);
        chk("b2b_interval", 32'(accept_cyc - t0), 32'(int'(WS) + 2 + int'(TC)));
        drain();
        chk("b2b_mem_0100", 32'(mem[16'h0100]), 32'hC3);

        // Reset in the second WSTROBE cycle aborts the write.
        issue(1'b1, 16'h7777, 8'h99, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_strobe", 32'(o_we_b), 32'd0);
        done0 = n_done;
        i_rst = 1'b1;
        @(negedge clk);
        chk("abort_ce_b",  32'(o_ce_b),  32'd1);
        chk("abort_re_b",  32'(o_re_b),  32'd1);
        chk("abort_we_b",  32'(o_we_b),  32'd1);
        chk("abort_bus",   32'(io_data), 32'hFF);
        chk("abort_ready", 32'(o_ready), 32'd1);
        i_rst = 1'b0;
        sb.delete();
        n_aborted++;
        repeat (int'(WR_LAT) + 4) @(negedge clk);
        chk("abort_no_done", 32'(n_done), 32'(done0));

        // Random traffic against the scoreboard.
        for (int k = 0; k < 256; k++) begin
            issue(1'($urandom_range(0, 1)), {8'h20, 8'($urandom)}, 8'($urandom), 1'b0,
                  (k != 255) && (1'($urandom_range(0, 1)) == 1'b1));
        end
        drain();

`ifdef SRAM_MASTER_AUTOINC_EN
        // Pointer load, then three pointer-based writes across the wrap.
        i_addr     = 16'hFFFE;
        i_we       = 1'b1;
        i_wdata    = 8'h11;
        i_req      = 1'b1;
        i_ptr_load = 1'b1;
        @(negedge clk);
        i_ptr_load = 1'b0;
        i_req      = 1'b0;
        chk("ptrload_no_access", 32'(o_ce_b), 32'd1);
        chk("ptrload_ready",     32'(o_ready), 32'd1);
        model_ptr = 16'hFFFE;
        issue(1'b1, 16'h1234, 8'h61, 1'b1, 1'b0);
        issue(1'b1, 16'h1234, 8'h62, 1'b1, 1'b0);
        issue(1'b1, 16'h1234, 8'h63, 1'b1, 1'b0);
        drain();
        chk("ptr_fffe", 32'(mem[16'hFFFE]), 32'h61);
        chk("ptr_ffff", 32'(mem[16'hFFFF]), 32'h62);
        chk("ptr_0000", 32'(mem[16'h0000]), 32'h63);
        chk("ptr_1234_kept", 32'(mem[16'h1234]), 32'hA5);
`endif

        chk("done_count", 32'(n_done), 32'(n_accept - n_aborted));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
